// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT (handshaked select) and SCAN (prescaled auto-step) modes.
// Define DECODER_ACTIVE_LOW_EN to drive the y pins inverted (idle/reset value all-ones).
module decoder_scan #(
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic                  sel_ready,
    output logic [2**SEL_W-1:0]   y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  wrap
);
    localparam int unsigned N    = 2 ** SEL_W;
    localparam int unsigned PS_W = $clog2(PRESCALE + 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic [PS_W-1:0]  ps_q, ps_d;

    assign sel_ready = en & ~mode;

    // Outputs are computed for the state being entered at this edge, so every
    // mode change takes effect with one cycle of latency.
    always_comb begin
        state_d  = ST_IDLE;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        wrap_d   = 1'b0;
        ps_d     = '0;
        if (en) begin
            state_d = mode ? ST_SCAN : ST_DIRECT;
        end
        unique case (state_d)
            ST_IDLE: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                idx_d    = '0;
            end
            ST_DIRECT: begin
                if (sel_valid && sel_ready) begin
                    onehot_d = N'(1) << sel;
                    idx_d    = sel;
                    valid_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    // Fresh sweep from line 0; prescaler restarts with no carry-over.
                    onehot_d = N'(1);
                    idx_d    = '0;
                    valid_d  = 1'b1;
                end else if (ps_q == PS_LAST) begin
                    idx_d    = idx_q + SEL_W'(1);
                    onehot_d = N'(1) << idx_d;
                    valid_d  = 1'b1;
                    wrap_d   = (idx_q == IDX_LAST);
                end else begin
                    ps_d = ps_q + PS_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            wrap_q   <= 1'b0;
            ps_q     <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            wrap_q   <= wrap_d;
            ps_q     <= ps_d;
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~onehot_q;
`else
    assign y = onehot_q;
`endif
    assign y_valid = valid_q;
    assign cur_idx = idx_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: driver pushes model expectations, monitor pops and compares each cycle.
module tb_decoder_scan;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned N        = 2 ** SEL_W;
`ifdef DECODER_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]     y;
        logic             y_valid;
        logic [SEL_W-1:0] idx;
        logic             wrap;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             sel_valid = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             sel_ready;
    logic [N-1:0]     y;
    logic             y_valid;
    logic [SEL_W-1:0] cur_idx;
    logic             wrap;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Reference model: which line is lit, and how many edges since SCAN entry.
    int   m_line = -1;
    bit   m_scan = 1'b0;
    int   m_t = 0;

    decoder_scan #(.SEL_W(SEL_W), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
        .y(y), .y_valid(y_valid), .cur_idx(cur_idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] pins(input logic [N-1:0] oh);
        return ACT_LOW ? ~oh : oh;
    endfunction

    function automatic exp_t model_out(input bit w);
        exp_t e;
        e.y       = pins((m_line < 0) ? '0 : (N'(1) << m_line));
        e.y_valid = (m_line >= 0);
        e.idx     = (m_line < 0) ? '0 : SEL_W'(m_line);
        e.wrap    = w;
        return e;
    endfunction

    // One clock of stimulus: drive between edges, predict the next edge's outputs.
    task automatic step(input logic e, input logic m, input logic sv, input logic [SEL_W-1:0] s);
        bit w;
        @(negedge clk);
        en = e; mode = m; sel_valid = sv; sel = s;
        #1;
        chk("sel_ready", 64'(sel_ready), 64'(e & ~m));
        w = 1'b0;
        if (!e) begin
            m_line = -1;
            m_scan = 1'b0;
        end else if (m) begin
            if (!m_scan) begin
                m_scan = 1'b1;
                m_t = 0;
            end else begin
                m_t++;
            end
            m_line = (m_t / PRESCALE) % N;
            w = (m_t > 0) && (m_t % (N * PRESCALE) == 0);
        end else begin
            m_scan = 1'b0;
            if (sv) m_line = int'(s);
        end
        exp_q.push_back(model_out(w));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0;
        m_line = -1; m_scan = 1'b0;
        exp_q.push_back(model_out(1'b0));
    endtask

    // Assert reset between edges and check outputs clear without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_y", 64'(y), 64'(pins('0)));
        chk("rst_y_valid", 64'(y_valid), 64'd0);
        chk("rst_cur_idx", 64'(cur_idx), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);
        release_reset();
    endtask

    // Monitor: outputs are presented every cycle out of reset.
    initial begin
        exp_t ex;
        logic [N-1:0] oh;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 64'd1, 64'd0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("y", 64'(y), 64'(ex.y));
                    chk("y_valid", 64'(y_valid), 64'(ex.y_valid));
                    chk("cur_idx", 64'(cur_idx), 64'(ex.idx));
                    chk("wrap", 64'(wrap), 64'(ex.wrap));
                    oh = ACT_LOW ? ~y : y;
                    chk("onehot0", 64'($onehot0(oh)), 64'd1);
                    chk("valid_eq_nonzero", 64'(y_valid), 64'(oh != '0));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic e, m, sv;
        #3;
        chk("init_rst_y", 64'(y), 64'(pins('0)));
        chk("init_rst_y_valid", 64'(y_valid), 64'd0);
        chk("init_rst_cur_idx", 64'(cur_idx), 64'd0);
        release_reset();

        // DIRECT: accept, hold, second accept.
        step(1, 0, 1, 2);
        repeat (10) step(1, 0, 0, SEL_W'($urandom));
        step(1, 0, 1, 3);
        step(1, 0, 1, 1);
        step(1, 0, 1, 0);

        // SCAN full sweep plus wrap; requests are ignored.
        step(0, 0, 0, 0);
        repeat (20) step(1, 1, 1'($urandom), SEL_W'($urandom));

        // Mode switch mid-step: hold, then accept, then restart scan.
        step(0, 0, 0, 0);
        repeat (9) step(1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (6) step(1, 1, 0, 0);

        // Enable drop from DIRECT; requests with en low are dropped.
        step(1, 0, 1, 1);
        step(0, 0, 1, 3);
        step(0, 0, 1, 2);
        step(0, 1, 1, 2);

        // Async reset in the middle of a sweep.
        repeat (6) step(1, 1, 0, 0);
        async_reset();

        // Randomized traffic with persistent mode runs.
        m = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) m = ~m;
            e  = ($urandom_range(0, 19) != 0);
            sv = 1'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            else step(e, m, sv, SEL_W'($urandom));
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
